stopwatch_core: RTL and testbench

- Downstream consumer of the frequency divider's slow square-wave output `tick`. Each rising edge of `tick` is one hundredth-of-a-second count.
- Holds the stopwatch time as BCD digits MM:SS.cc.
- Runs a run/stop/lap control FSM driven by the single-cycle, clk-synchronous `start_stop`, `lap` and `clear` button pulses.
- Feeds the display multiplexer stage.

---
 rtl/stopwatch_core.sv | 83 ++++++++
 tb/tb_stopwatch_core.sv | 127 ++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS.cc stopwatch counting tick rising edges, with a run/stop/lap control FSM.
module stopwatch_core #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUN, RUN_LAP, STOP} state_t;
  // Digit order, lowest first: cs_o, cs_t, sec_o, sec_t, min_o, min_t
  localparam logic [5:0][3:0] LIM = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [5:0][3:0] TOP = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 4'd5, 4'd9, 4'd9, 4'd9};
  state_t state_q, state_d;
  logic tick_q, tp, live, sat, clr, ovf_q, ovf_d;
  logic [5:0][3:0] cnt_q, cnt_d, lap_q, lap_d, disp_q;
  assign tp   = tick & ~tick_q;
  assign live = state_q == RUN || state_q == RUN_LAP;
  assign sat  = tp & live & (cnt_q == TOP);
  assign clr  = state_q == STOP && clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_stop ? RUN : IDLE;
      RUN:     state_d = (sat || start_stop) ? STOP : lap ? RUN_LAP : RUN;
      RUN_LAP: state_d = (sat || start_stop) ? STOP : lap ? RUN : RUN_LAP;
      STOP:    state_d = clear ? IDLE : (start_stop && !ovf_q) ? RUN : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin : cnt_p
    logic c;
    c = tp & live & ~sat;
    cnt_d = cnt_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = c ? ((cnt_q[i] == LIM[i]) ? 4'd0 : cnt_q[i] + 4'd1) : cnt_q[i];
      c = c & (cnt_q[i] == LIM[i]);
    end
    if (clr) cnt_d = '0;
  end
  assign lap_d = (state_q == RUN && lap && !start_stop) ? cnt_q : lap_q;
  assign ovf_d = clr ? 1'b0 : (ovf_q | sat);
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q     <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      disp_q     <= (state_q == RUN_LAP) ? lap_q : cnt_q;
      running    <= live;
      lap_active <= state_q == RUN_LAP;
      overflow   <= ovf_q;
    end
  end
  assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = disp_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed checks of the stopwatch counter, carries, lap, saturation and control priorities.
module tb_stopwatch_core;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] a_mt, a_mo, a_st, a_so, a_ct, a_co, b_mt, b_mo, b_st, b_so, b_ct, b_co;
  logic a_run, a_lap, a_ovf, b_run, b_lap, b_ovf;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  stopwatch_core u_a (.clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .min_t(a_mt), .min_o(a_mo), .sec_t(a_st), .sec_o(a_so), .cs_t(a_ct), .cs_o(a_co),
    .running(a_run), .lap_active(a_lap), .overflow(a_ovf));
  stopwatch_core #(.MAX_MIN(1)) u_b (.clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .min_t(b_mt), .min_o(b_mo), .sec_t(b_st), .sec_o(b_so), .cs_t(b_ct), .cs_o(b_co),
    .running(b_run), .lap_active(b_lap), .overflow(b_ovf));
  wire [23:0] a_dig = {a_mt, a_mo, a_st, a_so, a_ct, a_co};
  wire [23:0] b_dig = {b_mt, b_mo, b_st, b_so, b_ct, b_co};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      repeat (hold) step();
      tick = 1'b0;
      step();
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic pulse(input logic ss, input logic lp, input logic cl);
    start_stop = ss; lap = lp; clear = cl;
    step();
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step();
    step();
  endtask
  initial begin
    step();
    do_reset();
    chk("reset_digits", a_dig, 24'h000000);
    chk("reset_flags", {a_run, a_lap, a_ovf}, 3'b000);
    // A tick edge landing on the start cycle must not count
    tick = 1'b1; start_stop = 1'b1;
    step();
    tick = 1'b0; start_stop = 1'b0;
    step();
    ticks(150, 3);
    chk("run_150", a_dig, 24'h000150);
    chk("run_flags", {a_run, a_lap, a_ovf}, 3'b100);
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ticks(99, 1);
    chk("carry_099", a_dig, 24'h000099);
    ticks(1, 1);
    chk("carry_100", a_dig, 24'h000100);
    ticks(5899, 1);
    chk("carry_5999", a_dig, 24'h005999);
    ticks(1, 1);
    chk("carry_10000", a_dig, 24'h010000);
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ticks(237, 1);
    chk("lap_pre", a_dig, 24'h000237);
    lap = 1'b1;
    step();
    lap = 1'b0;
    ticks(50, 1);
    step();
    chk("lap_hold", a_dig, 24'h000237);
    chk("lap_flags", {a_run, a_lap}, 2'b11);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_release", a_dig, 24'h000287);
    chk("lap_rel_flags", {a_run, a_lap}, 2'b10);
    pulse(1'b0, 1'b0, 1'b1);
    chk("clear_in_run", a_dig, 24'h000287);
    chk("clear_in_run_flag", a_run, 1'b1);
    pulse(1'b1, 1'b1, 1'b0);
    chk("ss_beats_lap", {a_run, a_lap}, 2'b00);
    chk("ss_beats_lap_dig", a_dig, 24'h000287);
    pulse(1'b1, 1'b0, 1'b1);
    chk("clear_beats_ss", a_dig, 24'h000000);
    chk("clear_beats_ss_run", a_run, 1'b0);
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ticks(1000, 1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("rl_pre_dig", a_dig, 24'h001000);
    chk("rl_pre_lap", a_lap, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_dig", a_dig, 24'h000000);
    chk("midrst_flags", {a_run, a_lap, a_ovf}, 3'b000);
    ticks(3, 1);
    step();
    chk("midrst_idle", {a_dig, a_run}, 25'h0);
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ticks(11999, 1);
    chk("sat_pre", b_dig, 24'h015999);
    chk("sat_pre_flags", {b_run, b_ovf}, 2'b10);
    ticks(1, 1);
    step();
    chk("sat_dig", b_dig, 24'h015999);
    chk("sat_flags", {b_run, b_ovf}, 2'b01);
    pulse(1'b1, 1'b0, 1'b0);
    chk("sat_ss_ignored", {b_run, b_ovf}, 2'b01);
    ticks(2, 1);
    chk("sat_ss_dig", b_dig, 24'h015999);
    pulse(1'b0, 1'b0, 1'b1);
    chk("sat_clear_dig", b_dig, 24'h000000);
    chk("sat_clear_ovf", b_ovf, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
